// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the elastic pipeline stage: occupancy state
// encodings (decoded from `level` by hazard/debug logic) and helpers.
package pipe_skid_stage_pkg;

    // Occupancy state; the encoding is the beat count held by the stage.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    localparam int LEVEL_W = 2;

    // Occupancy count presented on `level` for a given state.
    function automatic logic [LEVEL_W-1:0] state_level(input skid_state_e s);
        return LEVEL_W'(s);
    endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready payload channel between two pipeline stages.
interface pipe_skid_stage_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    // Producer side of the channel.
    modport master (output valid, output data, input ready);
    // Consumer side of the channel.
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_stage_data_reg.sv
// WIDTH-bit payload register with load enable and synchronous clear to
// the bubble value; asynchronous reset also loads the bubble value.
module pipe_skid_stage_data_reg #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next value: clear beats load, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = RST_VAL;
        end else if (ld) begin
            data_d = d;
        end else begin
            data_d = data_q;
        end
    end

    // Payload storage flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;
endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage: head register plus one skid entry, with
// registered in_ready/out_valid so back-pressure never crosses stages
// combinationally. Flush discards everything held in one cycle.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    pipe_skid_stage_if.slave      in_if,
    pipe_skid_stage_if.master     out_if,
    output logic [LEVEL_W-1:0]    level
);
    skid_state_e      state_q;
    skid_state_e      state_d;
    logic             in_ready_q;
    logic             in_ready_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic             in_fire_s;
    logic             out_fire_s;
    logic             main_ld_s;
    logic             skid_ld_s;
    logic [WIDTH-1:0] main_din_s;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    // Next-state and register-load decode; flush overrides every transition.
    always_comb begin
        in_fire_s  = in_if.valid & in_ready_q;
        out_fire_s = out_valid_q & out_if.ready;
        state_d    = state_q;
        main_ld_s  = 1'b0;
        skid_ld_s  = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_d   = ST_BUSY;
                        main_ld_s = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (in_fire_s && out_fire_s) begin
                        state_d   = ST_BUSY;
                        main_ld_s = 1'b1;
                    end else if (in_fire_s) begin
                        state_d   = ST_FULL;
                        skid_ld_s = 1'b1;
                    end else if (out_fire_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
                ST_FULL: begin
                    if (out_fire_s) begin
                        state_d   = ST_BUSY;
                        main_ld_s = 1'b1;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        // Handshake outputs are decoded from the next state and registered.
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // Head is refilled from skid when draining FULL, else from the input.
    assign main_din_s = (state_q == ST_FULL) ? skid_q : in_if.data;

    // State and registered handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    pipe_skid_stage_data_reg #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_main (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .ld  (main_ld_s),
        .d   (main_din_s),
        .q   (main_q)
    );

    pipe_skid_stage_data_reg #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_skid (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .ld  (skid_ld_s),
        .d   (in_if.data),
        .q   (skid_q)
    );

    assign in_if.ready  = in_ready_q;
    assign out_if.valid = out_valid_q;
    assign out_if.data  = main_q;
    assign level        = state_level(state_q);
endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and randomised checks of pipe_skid_stage at WIDTH=97 and
// WIDTH=8, both driven by the same handshake and compared to a queue.
module tb_pipe_skid_stage;
    localparam logic [96:0] RV97 = 97'h1_2345_6789_ABCD_EF01_2345_6789;
    localparam logic [7:0]  RV8  = 8'hC3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic [1:0] level97;
    logic [1:0] level8;

    always #5 clk = ~clk;

    pipe_skid_stage_if #(.WIDTH(97)) in97 ();
    pipe_skid_stage_if #(.WIDTH(97)) out97 ();
    pipe_skid_stage_if #(.WIDTH(8))  in8 ();
    pipe_skid_stage_if #(.WIDTH(8))  out8 ();

    assign in8.valid  = in97.valid;
    assign in8.data   = in97.data[7:0];
    assign out8.ready = out97.ready;

    pipe_skid_stage #(.WIDTH(97), .RST_VAL(RV97)) dut97 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_if(in97), .out_if(out97), .level(level97)
    );

    pipe_skid_stage #(.WIDTH(8), .RST_VAL(RV8)) dut8 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_if(in8), .out_if(out8), .level(level8)
    );

    int          total = 0;
    int          bad = 0;
    logic [96:0] sbq[$];
    int          exp_level = 0;
    bit          exp_bubble = 1'b1;

    task automatic chk(input string tag, input logic [96:0] obs, input logic [96:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        logic [96:0] ed;
        logic [7:0]  ed8;
        chk("level97", 97'(level97), 97'(exp_level));
        chk("level8", 97'(level8), 97'(exp_level));
        chk("in_ready97", 97'(in97.ready), 97'(exp_level != 2));
        chk("in_ready8", 97'(in8.ready), 97'(exp_level != 2));
        chk("out_valid97", 97'(out97.valid), 97'(exp_level != 0));
        chk("out_valid8", 97'(out8.valid), 97'(exp_level != 0));
        if (exp_level != 0 || exp_bubble) begin
            if (exp_level != 0) begin
                ed  = sbq[0];
                ed8 = ed[7:0];
            end else begin
                ed  = RV97;
                ed8 = RV8;
            end
            chk("out_data97", out97.data, ed);
            chk("out_data8", 97'(out8.data), 97'(ed8));
        end
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model.
    task automatic cycle(input bit iv, input logic [96:0] d, input bit ordy, input bit fl);
        bit inf;
        bit outf;
        in97.valid  = iv;
        in97.data   = d;
        out97.ready = ordy;
        flush       = fl;
        check_outputs();
        inf  = iv && (exp_level != 2);
        outf = (exp_level != 0) && ordy;
        if (outf) void'(sbq.pop_front());
        if (fl) begin
            sbq.delete();
            exp_level  = 0;
            exp_bubble = 1'b1;
        end else begin
            if (inf) begin
                sbq.push_back(d);
                exp_bubble = 1'b0;
            end
            exp_level = exp_level + int'(inf) - int'(outf);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        sbq.delete();
        exp_level  = 0;
        exp_bubble = 1'b1;
    endtask

    initial begin
        logic [96:0] cnt;
        int          lvl;
        bit          iv;
        bit          ordy;
        bit          fl;

        // Reset
        in97.valid  = 1'b0;
        in97.data   = 97'd0;
        out97.ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(1'b0, 97'd0, 1'b0, 1'b0);

        // Streaming with out_ready held high
        cycle(1'b1, 97'h1, 1'b1, 1'b0);
        cycle(1'b1, 97'h2, 1'b1, 1'b0);
        cycle(1'b1, 97'h3, 1'b1, 1'b0);
        chk("stream_data3", out97.data, 97'h3);
        chk("stream_level", 97'(level97), 97'd1);
        cycle(1'b0, 97'd0, 1'b1, 1'b0);

        // Skid fill
        cycle(1'b1, 97'hA, 1'b0, 1'b0);
        cycle(1'b1, 97'hB, 1'b0, 1'b0);
        chk("skid_level", 97'(level97), 97'd2);
        chk("skid_in_ready", 97'(in97.ready), 97'd0);
        chk("skid_head", out97.data, 97'hA);
        cycle(1'b1, 97'hFF, 1'b0, 1'b0);
        chk("skid_stable", out97.data, 97'hA);
        cycle(1'b0, 97'd0, 1'b1, 1'b0);
        chk("skid_second", out97.data, 97'hB);
        chk("skid_ready_back", 97'(in97.ready), 97'd1);
        cycle(1'b0, 97'd0, 1'b1, 1'b0);
        cycle(1'b0, 97'd0, 1'b0, 1'b0);

        // Simultaneous fire in BUSY
        cycle(1'b1, 97'h5, 1'b0, 1'b0);
        cycle(1'b1, 97'h6, 1'b1, 1'b0);
        chk("simul_data", out97.data, 97'h6);
        chk("simul_level", 97'(level97), 97'd1);
        cycle(1'b0, 97'd0, 1'b1, 1'b0);

        // Flush while FULL with a valid input
        cycle(1'b1, 97'h7, 1'b0, 1'b0);
        cycle(1'b1, 97'h8, 1'b0, 1'b0);
        cycle(1'b1, 97'hC, 1'b0, 1'b1);
        chk("flush_level", 97'(level97), 97'd0);
        chk("flush_data", out97.data, RV97);
        cycle(1'b0, 97'd0, 1'b1, 1'b0);

        // Flush in BUSY with an accepted input, then accept right after
        cycle(1'b1, 97'h9, 1'b0, 1'b0);
        cycle(1'b1, 97'hD, 1'b1, 1'b1);
        chk("flush2_valid", 97'(out97.valid), 97'd0);
        cycle(1'b1, 97'hE, 1'b1, 1'b0);
        chk("post_flush_data", out97.data, 97'hE);
        cycle(1'b0, 97'd0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle while FULL
        cycle(1'b1, 97'hF, 1'b0, 1'b0);
        cycle(1'b1, 97'h10, 1'b0, 1'b0);
        chk("pre_rst_level", 97'(level97), 97'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_level97", 97'(level97), 97'd0);
        chk("arst_level8", 97'(level8), 97'd0);
        chk("arst_valid97", 97'(out97.valid), 97'd0);
        chk("arst_data97", out97.data, RV97);
        chk("arst_data8", 97'(out8.data), 97'(RV8));
        chk("arst_in_ready", 97'(in97.ready), 97'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(1'b0, 97'd0, 1'b0, 1'b0);

        // Randomised handshake with incrementing payload
        cnt = 97'd1;
        for (int i = 0; i < 10000; i++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 199) == 0);
            lvl  = exp_level;
            cycle(iv, (cnt << 64) | cnt, ordy, fl);
            if (iv && lvl != 2) cnt = cnt + 97'd1;
        end

        // Drain
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 97'd0, 1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised elastic pipeline stage register, the successor to the fixed stall-driven inter-stage flop bank. It carries one WIDTH-bit payload per beat between two pipeline stages using a valid/ready handshake, a two-entry skid buffer and a synchronous flush. Every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiates it with the concatenated stage bundle as payload. It sustains one beat per cycle with fully registered `in_ready`, so back-pressure never forms a combinational path across stages.

## Interface
Parameters:
- `WIDTH`, default 32: payload width in bits (≥1).
- `RST_VAL`, default 0 (WIDTH bits): value loaded into both data registers on reset and on flush, i.e. the bubble value.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `flush`  input  1  synchronous discard of all held beats.
- `in_valid`  input  1  upstream beat present.
- `in_ready`  output  1  stage can accept a beat; depends only on state.
- `in_data`  input  WIDTH  upstream payload.
- `out_valid`  output  1  beat presented downstream.
- `out_ready`  input  1  downstream accepts.
- `out_data`  output  WIDTH  payload of the head beat.
- `level`  output  2  occupancy: 0, 1 or 2.

## Operation
- Storage: `main` register (head, drives `out_data`) and `skid` register. State is EMPTY (0), BUSY (1), FULL (2). `level` equals the state encoding.
- `in_ready = (state != FULL)`. `out_valid = (state != EMPTY)`. `out_data = main`.
- Input fire: `in_valid & in_ready`. Output fire: `out_valid & out_ready`.
- EMPTY:
  - in fire → BUSY, `main <= in_data`.
  - no in fire → stay EMPTY.
- BUSY:
  - in fire and out fire → BUSY, `main <= in_data`.
  - in fire only → FULL, `skid <= in_data`.
  - out fire only → EMPTY.
  - neither → stay BUSY.
- FULL: `in_ready` is 0.
  - out fire → BUSY, `main <= skid`.
  - no out fire → stay FULL.
- Flush has highest priority. Next state is EMPTY and `main`, `skid` <= RST_VAL, whatever the fire signals.
  - An input fire in the flush cycle is accepted (upstream sees the handshake complete) and discarded.
  - An output fire in the flush cycle counts as delivered.
- Ordering: beats leave in acceptance order. No beat is duplicated or lost except by flush.
- Stability: while `out_valid & !out_ready & !flush`, `out_data` holds its value.
- Registers not written in a transition hold their value. A stale `skid` value is don't-care, but it must not reach `out_data`.

## Timing
- Reset (async assert, sync release): state EMPTY, `main` = `skid` = RST_VAL.
  - Outputs during and after reset: `out_valid` = 0, `out_data` = RST_VAL, `level` = 0, `in_ready` = 1.
- Reset mid-operation: held beats are discarded immediately, without waiting for a clock edge.
- Latency: a beat accepted at edge N is on `out_data` with `out_valid` = 1 after edge N, so it can fire downstream in cycle N+1.
- Throughput: 1 beat/cycle while `out_ready` is held high. The stage never enters FULL under continuous drain.
- Back-pressure: `in_ready` falls one cycle after `out_ready` falls with a beat in flight. That cycle's input beat is captured in `skid`.
- Flush: one cycle. `out_valid` = 0 and `level` = 0 from the next cycle. A beat can be accepted in the cycle right after flush.
- No combinational path from `out_ready` to `in_ready`, and none from `in_*` to `out_*`.

## Structure
- State encodings EMPTY/BUSY/FULL (2-bit) go in the shared header next to the bus-width macros, so hazard and debug logic can decode `level`.
- Stage bundle widths (e.g. EX/MEM payload width = sum of its field widths) are defined as shared constants. Each instantiating stage packs and unpacks its bundle around this block.
- No sub-module is required. An optional `pipe_data_reg` (WIDTH-bit register with load enable and sync clear to RST_VAL) may be used twice for `main` and `skid`.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle with `level` = 2 → `out_valid` = 0, `level` = 0 and `out_data` = RST_VAL immediately, with no clock edge needed. After release, `in_ready` = 1.
- Streaming: with `out_ready` = 1, drive `in_data` 0x1, 0x2, 0x3 on consecutive cycles → `out_data` shows 0x1, 0x2, 0x3 one cycle later each, and `level` never exceeds 1.
- Skid fill:
  - Send 0xA, drop `out_ready` the same cycle, then send 0xB → `level` = 2, `in_ready` = 0, `out_data` = 0xA stable.
  - Raise `out_ready` → 0xA then 0xB delivered on consecutive cycles, and `in_ready` returns to 1 after the first.
- Flush with input: `level` = 2, assert `flush` together with a valid input 0xC → next cycle `level` = 0, `out_valid` = 0, `out_data` = RST_VAL, and 0xC never appears.
- Randomised handshake: 10k cycles of random `in_valid`/`out_ready` with an incrementing payload, WIDTH = 8 and WIDTH = 97 → scoreboard shows in-order, lossless delivery and `out_data` stable under back-pressure.
- Simultaneous fire in BUSY: `main` = 0x5, in fire 0x6 and out fire in the same cycle → 0x5 delivered, next `out_data` = 0x6, `level` stays 1.
